// File: rtl/adc_avg_filter.sv
// adc_avg_filter: moving average over the last 2^LOG2_DEPTH ADC samples,
// with peak hold and a hysteretic over-range alarm.
module adc_avg_filter #(
  parameter int DATA_W     = 12,
  parameter int LOG2_DEPTH = 3
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iSAMPLE,
  input  logic              iSAMPLE_VALID,
  input  logic              iCLR,
  input  logic [DATA_W-1:0] iTHRESH_HI,
  input  logic [DATA_W-1:0] iTHRESH_LO,
  output logic [DATA_W-1:0] oAVG,
  output logic              oAVG_VALID,
  output logic              oFILLED,
  output logic [DATA_W-1:0] oPEAK,
  output logic              oALARM
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr;
  logic [CNT_W-1:0]      fcnt;
  logic [CNT_W-1:0]      fcnt_nxt;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_nxt;
  logic                  accept;

  // Next-state values for one accepted sample; clear overrides a coincident strobe.
  always_comb begin
    accept   = iSAMPLE_VALID & ~iCLR;
    fcnt_nxt = (fcnt == FULL) ? FULL : fcnt + CNT_W'(1);
    sum_nxt  = sum + SUM_W'(iSAMPLE) - SUM_W'(mem[wptr]);
  end

  // Circular sample buffer; entries are zeroed so the running sum stays exact after a flush.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (iCLR) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wptr] <= iSAMPLE;
    end
  end

  // Window bookkeeping: pointer, fill count, running sum, peak.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wptr    <= '0;
      fcnt    <= '0;
      sum     <= '0;
      oPEAK   <= '0;
      oFILLED <= 1'b0;
    end else if (iCLR) begin
      wptr    <= '0;
      fcnt    <= '0;
      sum     <= '0;
      oPEAK   <= '0;
      oFILLED <= 1'b0;
    end else if (accept) begin
      wptr    <= wptr + LOG2_DEPTH'(1);
      fcnt    <= fcnt_nxt;
      sum     <= sum_nxt;
      oFILLED <= (fcnt_nxt == FULL);
      if (iSAMPLE > oPEAK) oPEAK <= iSAMPLE;
    end
  end

  // Average publish: only once the window is full; oAVG holds through warm-up and clear.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oAVG       <= '0;
      oAVG_VALID <= 1'b0;
    end else begin
      oAVG_VALID <= 1'b0;
      if (accept && (fcnt_nxt == FULL)) begin
        oAVG       <= sum_nxt[SUM_W-1:LOG2_DEPTH];
        oAVG_VALID <= 1'b1;
      end
    end
  end

  // Alarm evaluated the cycle after each average pulse; a clear cancels that evaluation.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oALARM <= 1'b0;
    end else if (iCLR) begin
      oALARM <= 1'b0;
    end else if (oAVG_VALID) begin
      if (oAVG > iTHRESH_HI)      oALARM <= 1'b1;
      else if (oAVG < iTHRESH_LO) oALARM <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter with hand-computed expectations.
module tb_adc_avg_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample;
  logic        sample_valid;
  logic        clr;
  logic [11:0] thresh_hi;
  logic [11:0] thresh_lo;
  logic [11:0] avg;
  logic        avg_valid;
  logic        filled;
  logic [11:0] peak;
  logic        alarm;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;
  int vsnap;

  adc_avg_filter #(.DATA_W(12), .LOG2_DEPTH(3)) dut (
    .iCLK(clk), .iRST(rst), .iSAMPLE(sample), .iSAMPLE_VALID(sample_valid),
    .iCLR(clr), .iTHRESH_HI(thresh_hi), .iTHRESH_LO(thresh_lo),
    .oAVG(avg), .oAVG_VALID(avg_valid), .oFILLED(filled),
    .oPEAK(peak), .oALARM(alarm)
  );

  always #5 clk = ~clk;

  // Count average pulses a little after each rising edge.
  always @(posedge clk) begin
    #2;
    if (avg_valid) vcnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait gap cycles, present one sample for one cycle, return at the negedge after its edge.
  task automatic strobe(input logic [11:0] s, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    sample       = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  logic [11:0] step_avg [8] = '{12'h8FF, 12'h9FF, 12'hAFF, 12'hBFF,
                                12'hCFF, 12'hDFF, 12'hEFF, 12'hFFF};
  logic        step_alm [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic [11:0] zero_avg [8] = '{12'hDFF, 12'hBFF, 12'h9FF, 12'h7FF,
                                12'h5FF, 12'h3FF, 12'h1FF, 12'h000};
  logic        zero_alm [8] = '{1, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    rst = 1'b1; sample = '0; sample_valid = 1'b0; clr = 1'b0;
    thresh_hi = 12'hC00; thresh_lo = 12'h400;
    repeat (3) @(negedge clk);
    chk("rst_avg", avg, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_filled", filled, 0);
    chk("rst_peak", peak, 0);
    chk("rst_alarm", alarm, 0);
    rst = 1'b0;

    // Warm-up at mid scale, 16-cycle spacing.
    for (int i = 1; i <= 8; i++) begin
      strobe(12'h800, 15);
      if (i < 8) begin
        chk("warm_novalid", vcnt, 0);
        chk("warm_filled", filled, 0);
      end
    end
    chk("warm_avg", avg, 12'h800);
    chk("warm_valid", avg_valid, 1);
    chk("warm_filled8", filled, 1);
    @(negedge clk);
    chk("warm_pulse1", vcnt, 1);
    chk("warm_alarm", alarm, 0);

    // Step to full scale; alarm checked one cycle after each average.
    for (int i = 0; i < 8; i++) begin
      strobe(12'hFFF, 3);
      chk("step_avg", avg, step_avg[i]);
      if (i == 4) chk("step_alarm_lat", alarm, 0);
      @(negedge clk);
      chk("step_alarm", alarm, step_alm[i]);
    end
    chk("step_peak", peak, 12'hFFF);

    // Decay to zero: alarm holds in the band and drops below the low level.
    for (int i = 0; i < 8; i++) begin
      strobe(12'h000, 3);
      chk("zero_avg", avg, zero_avg[i]);
      @(negedge clk);
      chk("zero_alarm", alarm, zero_alm[i]);
    end

    // Back-to-back strobes after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample = 12'h010;
    sample_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("b2b_valid", avg_valid, (i >= 8) ? 1 : 0);
      if (i >= 8) chk("b2b_avg", avg, 12'h010);
      if (i == 10) sample_valid = 1'b0;
    end

    // Clear collision with a full window at full scale and alarm set.
    for (int i = 0; i < 8; i++) strobe(12'hFFF, 0);
    @(negedge clk);
    chk("col_pre_alarm", alarm, 1);
    clr = 1'b1; sample = 12'h123; sample_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; sample_valid = 1'b0;
    chk("col_filled", filled, 0);
    chk("col_peak", peak, 0);
    chk("col_alarm", alarm, 0);
    chk("col_valid", avg_valid, 0);
    chk("col_avg", avg, 12'hFFF);
    vsnap = vcnt;
    for (int i = 1; i <= 8; i++) begin
      strobe(12'h100, 1);
      if (i < 8) chk("col_novalid", vcnt, vsnap);
    end
    chk("col_avg2", avg, 12'h100);
    chk("col_peak2", peak, 12'h100);

    // Async reset during warm-up at fcnt = 5.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) strobe(12'h200, 2);
    chk("ar_pre_peak", peak, 12'h200);
    chk("ar_pre_avg", avg, 12'h100);
    #2 rst = 1'b1;
    #1;
    chk("ar_avg", avg, 0);
    chk("ar_peak", peak, 0);
    chk("ar_filled", filled, 0);
    chk("ar_alarm", alarm, 0);
    chk("ar_valid", avg_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    vsnap = vcnt;
    for (int i = 1; i <= 8; i++) begin
      strobe(12'h300, 1);
      if (i < 8) chk("ar_novalid", vcnt, vsnap);
    end
    chk("ar_avg2", avg, 12'h300);
    chk("ar_valid2", avg_valid, 1);
    chk("ar_filled2", filled, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
# adc_avg_filter

Moving-average filter and threshold monitor placed directly downstream of the serial ADC controller. Takes each new 12-bit conversion result, with a one-cycle strobe, and keeps a running sum over the last 2^LOG2_DEPTH samples in a circular buffer. It publishes the truncated average, a peak-hold value and a hysteretic over-range alarm for system logic.

## Interface
- DATA_W, 12: sample width; matches ADC result width.
- LOG2_DEPTH, 3: log2 of averaging window (DEPTH = 8); legal range 1..6.
- iCLK  in  1  system clock; all state changes on posedge.
- iRST  in  1  asynchronous, active-high reset.
- iSAMPLE  in  DATA_W  ADC conversion result, unsigned.
- iSAMPLE_VALID  in  1  one-cycle strobe; iSAMPLE is valid this cycle. May be high on consecutive cycles.
- iCLR  in  1  synchronous flush of window, fill count, peak and alarm.
- iTHRESH_HI  in  DATA_W  alarm set level (strictly greater than).
- iTHRESH_LO  in  DATA_W  alarm clear level (strictly less than); iTHRESH_LO <= iTHRESH_HI required, else behaviour unspecified.
- oAVG  out  DATA_W  latest window average.
- oAVG_VALID  out  1  one-cycle pulse when oAVG updates.
- oFILLED  out  1  level; window holds DEPTH samples since reset or clear.
- oPEAK  out  DATA_W  maximum sample accepted since reset or clear.
- oALARM  out  1  hysteretic over-threshold flag.

## Operation
- Storage: DEPTH x DATA_W buffer, write pointer wptr (LOG2_DEPTH bits, wraps DEPTH-1 -> 0), fill counter fcnt (0..DEPTH, saturating), running sum (DATA_W+LOG2_DEPTH bits, no overflow possible).
- Accept (iSAMPLE_VALID=1, iCLR=0): sum <= sum + iSAMPLE - buf[wptr]; buf[wptr] <= iSAMPLE; wptr <= wptr+1; fcnt <= min(fcnt+1, DEPTH); oPEAK <= max(oPEAK, iSAMPLE).
- Average: oAVG <= new_sum >> LOG2_DEPTH (truncation, no rounding). Updated and oAVG_VALID pulsed only on an accept where the post-accept fcnt == DEPTH, i.e. from the DEPTH-th sample onward. During warm-up oAVG holds its prior value.
- oFILLED = (fcnt == DEPTH), registered.
- Alarm: evaluated one cycle after each oAVG_VALID pulse, using oAVG. If oAVG > iTHRESH_HI, set. If oAVG < iTHRESH_LO, clear. Otherwise hold.
- Clear (iCLR=1): buffer entries, sum, wptr, fcnt, oPEAK and oALARM go to 0; oAVG holds. iCLR wins over a coincident iSAMPLE_VALID; that sample is dropped, with no oAVG_VALID pulse. A pending alarm evaluation is cancelled.
- Reset: all registers, including buffer contents, go to 0 asynchronously. Outputs oAVG=0, oAVG_VALID=0, oFILLED=0, oPEAK=0, oALARM=0. Reset mid-window discards partial window; refill starts from zero.

## Timing
- Accept at edge k -> oAVG, oAVG_VALID, oPEAK, oFILLED visible after edge k (latency 1).
- oALARM visible after edge k+1 (latency 2 from accepting edge).
- Throughput: one sample per cycle sustained; no backpressure, no ready signal.
- Pipeline: at most one alarm evaluation in flight. Back-to-back accepts each evaluate against their own oAVG.
- Threshold inputs are sampled at the evaluation edge. Changing them between samples takes effect at the next evaluation.

## Test plan
- Warm-up: reset, then 8 strobes of 0x800 spaced 16 cycles. No oAVG_VALID on strobes 1-7, oFILLED=0. After strobe 8: oAVG=0x800, single oAVG_VALID pulse, oFILLED=1.
- Step/wrap: continue with 8 strobes of 0xFFF. Averages are 0x8FF after the 1st, 0xBFF after the 4th, 0xCFF after the 5th and 0xFFF after the 8th. Pointer wraps; oPEAK=0xFFF.
- Hysteresis: HI=0xC00, LO=0x400, run the step test. oALARM rises 2 cycles after the 5th 0xFFF strobe. Feeding 0x000 keeps oALARM=1 until oAVG < 0x400, then it drops, and 0x400 <= oAVG <= 0xC00 holds state.
- Back-to-back: 10 consecutive-cycle strobes of 0x010 after reset. oAVG_VALID is high on cycles 8-10 with oAVG=0x010 each time.
- Clear collision: full window at 0xFFF with alarm set, then iCLR and iSAMPLE_VALID (0x123) in the same cycle. Next cycle shows oFILLED=0, oPEAK=0, oALARM=0, no oAVG_VALID, and oAVG still 0xFFF. The sample 0x123 is absent from the next window.
- Async reset: assert iRST mid-cycle during warm-up (fcnt=5). All outputs go to 0 without a clock edge. After release, 8 new samples are required before oAVG_VALID.
